// File: rtl/freq_meter.sv
// freq_meter: gated rising-edge counter. Counts synchronized rising edges of
// sig_in over a window of GATE_CYCLES reference cycles, then holds the result
// under a valid/ack handshake until the consumer takes it.
module freq_meter #(
    parameter int GATE_CYCLES = 100,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK_in,
    input  logic             RST,
    input  logic             sig_in,
    input  logic             start,
    input  logic             ack,
    output logic             busy,
    output logic             valid,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t                   state_q;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     hist_q;
    logic [GW-1:0]            gate_q;
    logic [CNT_W-1:0]         count_q;
    logic                     ovf_q;
    logic                     busy_q;
    logic                     valid_q;
    logic                     sig_sync;
    logic                     edge_det;

    // Synchronizer chain plus history flop; the history runs in every state so
    // a signal that is already high when the window opens is not seen as an edge.
    always_ff @(posedge CLK_in or negedge RST) begin
        if (!RST) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sig_sync = sync_q[SYNC_STAGES-1];
    assign edge_det = sig_sync & ~hist_q;

    // Measurement FSM with registered busy/valid and a saturating edge counter.
    always_ff @(posedge CLK_in or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            gate_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= MEASURE;
                        gate_q  <= '0;
                        count_q <= '0;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                MEASURE: begin
                    // Edge in the last gate cycle is still counted.
                    if (edge_det) begin
                        if (count_q == {CNT_W{1'b1}}) begin
                            ovf_q <= 1'b1;
                        end else begin
                            count_q <= count_q + CNT_W'(1);
                        end
                    end
                    if (gate_q == GATE_LAST) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                    end else begin
                        gate_q <= gate_q + GW'(1);
                    end
                end
                DONE: begin
                    // start is ignored here, even alongside ack; result stays put.
                    if (ack) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign valid    = valid_q;
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: a default-width instance fed a slow square
// wave and a CNT_W=4 instance fed a per-cycle toggle, sharing the handshake.
module tb_freq_meter;

    logic       CLK_in = 1'b0;
    logic       RST    = 1'b0;
    logic       sig_a  = 1'b0;
    logic       sig_b  = 1'b0;
    logic       start  = 1'b0;
    logic       ack    = 1'b0;
    logic       busy_a, valid_a, ovf_a;
    logic [7:0] count_a;
    logic       busy_b, valid_b, ovf_b;
    logic [3:0] count_b;

    int checks = 0;
    int errors = 0;
    int mode   = 1;   // 0: sig_a low, 1: toggle every 5 cycles, 2: sig_a high
    int ph     = 0;

    freq_meter #(.GATE_CYCLES(100), .CNT_W(8), .SYNC_STAGES(2)) u_dut_a (
        .CLK_in(CLK_in), .RST(RST), .sig_in(sig_a), .start(start), .ack(ack),
        .busy(busy_a), .valid(valid_a), .count(count_a), .overflow(ovf_a)
    );

    freq_meter #(.GATE_CYCLES(100), .CNT_W(4), .SYNC_STAGES(2)) u_dut_b (
        .CLK_in(CLK_in), .RST(RST), .sig_in(sig_b), .start(start), .ack(ack),
        .busy(busy_b), .valid(valid_b), .count(count_b), .overflow(ovf_b)
    );

    always #5 CLK_in = ~CLK_in;

    // stimulus sources, updated between clock edges
    always @(posedge CLK_in) begin
        #2;
        sig_b = ~sig_b;
        ph = ph + 1;
        case (mode)
            0: sig_a = 1'b0;
            2: sig_a = 1'b1;
            default: if (ph % 5 == 0) sig_a = ~sig_a;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_in);
        #1;
    endtask

    // Pulse start, count busy cycles; optionally re-pulse start / pulse ack mid-window.
    task automatic run_window(input string tag, input int start_at, input int ack_at);
        int n;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy_on"}, busy_a, 1);
        chk({tag, "_valid_off"}, valid_a, 0);
        n = 0;
        while (busy_a && n < 200) begin
            start = (n == start_at);
            ack   = (n == ack_at);
            tick();
            n++;
        end
        start = 1'b0;
        ack   = 1'b0;
        chk({tag, "_window"}, n, 100);
        chk({tag, "_valid"}, valid_a, 1);
    endtask

    initial begin
        // reset state
        repeat (3) tick();
        chk("rst_busy", busy_a, 0);
        chk("rst_valid", valid_a, 0);
        chk("rst_count", count_a, 0);
        chk("rst_ovf", ovf_a, 0);
        RST = 1'b1;
        repeat (5) tick();

        // T1: period-10 signal, result held until ack
        run_window("t1", -1, -1);
        chk("t1_count", count_a, 10);
        chk("t1_ovf", ovf_a, 0);
        repeat (5) tick();
        chk("t1_hold_valid", valid_a, 1);
        chk("t1_hold_count", count_a, 10);
        // T3 rides on the same window: per-cycle toggle saturates the 4-bit counter
        chk("t3_count", count_b, 15);
        chk("t3_ovf", ovf_b, 1);
        chk("t3_valid", valid_b, 1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("t1_ack_valid", valid_a, 0);
        chk("t1_ack_count", count_a, 10);
        chk("t1_ack_busy", busy_a, 0);

        // T2: signal high well before start -> no false edge
        mode = 2;
        repeat (10) tick();
        run_window("t2", -1, -1);
        chk("t2_count", count_a, 0);
        chk("t2_ovf", ovf_a, 0);
        ack = 1'b1;
        tick();
        ack = 1'b0;

        // T4: starts during MEASURE/DONE and ack during MEASURE are ignored
        mode = 1;
        repeat (10) tick();
        run_window("t4", 20, 30);
        chk("t4_count", count_a, 10);
        start = 1'b1;
        repeat (3) tick();
        chk("t4_done_valid", valid_a, 1);
        chk("t4_done_busy", busy_a, 0);
        chk("t4_done_count", count_a, 10);
        start = 1'b0;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("t4_ack_valid", valid_a, 0);
        tick();
        chk("t4_no_restart", busy_a, 0);

        // T5: reset pulse at gate cycle 50 aborts immediately
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (50) tick();
        chk("t5_midwin_busy", busy_a, 1);
        RST = 1'b0;
        #1;
        chk("t5_rst_busy", busy_a, 0);
        chk("t5_rst_valid", valid_a, 0);
        chk("t5_rst_count", count_a, 0);
        tick();
        RST = 1'b1;
        repeat (3) tick();
        chk("t5_after_valid", valid_a, 0);
        run_window("t5", -1, -1);
        chk("t5_count", count_a, 10);

        // T6: start+ack together in DONE -> IDLE, no new window
        start = 1'b1;
        ack   = 1'b1;
        tick();
        start = 1'b0;
        ack   = 1'b0;
        chk("t6_valid", valid_a, 0);
        chk("t6_busy", busy_a, 0);
        tick();
        chk("t6_idle", busy_a, 0);
        run_window("t6", -1, -1);
        chk("t6_count", count_a, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
